// File: rtl/prog_alu_seq.sv
// Program-driven chained ALU sequencer: fetches words from a combinational ROM and
// evaluates ((a op1 d) op2 b) op3 c per word, returning results over valid/ready.
module prog_alu_seq #(
  parameter int unsigned DW     = 4,
  parameter int unsigned RW     = 8,
  parameter int unsigned ADDR_W = 4,
  parameter bit          SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4*DW+6:0]   rom_data,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_data,
  output logic              res_ovf,
  output logic              done
);

  localparam int unsigned PW = 2 * RW;
  localparam logic [ADDR_W-1:0] PC_MAX = '1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef struct packed {
    logic          last;
    logic [1:0]    op3;
    logic [1:0]    op2;
    logic [1:0]    op1;
    logic [DW-1:0] d;
    logic [DW-1:0] c;
    logic [DW-1:0] b;
    logic [DW-1:0] a;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t            state;
  instr_t            ins;
  logic [ADDR_W-1:0] pc;
  logic [RW-1:0]     w;

  logic [1:0]        op_sel;
  logic [RW-1:0]     x_sel;
  logic [RW-1:0]     y_sel;
  logic [RW:0]       step_res;

  // One ALU step; result is {flag, value} where flag marks wrap/saturate.
  function automatic logic [RW:0] alu_step(input logic [1:0]    op,
                                           input logic [RW-1:0] x,
                                           input logic [RW-1:0] y);
    logic [PW-1:0] full;
    logic          hi;
    logic          lo;
    full = '0;
    hi   = 1'b0;
    lo   = 1'b0;
    case (op)
      OP_ADD:  full = PW'(x) + PW'(y);
      OP_SUB: begin
        full = PW'(x) - PW'(y);
        lo   = (x < y);
      end
      OP_MUL:  full = PW'(x) * PW'(y);
      default: full = PW'(x);
    endcase
    if (op != OP_SUB) hi = |full[PW-1:RW];
    if (SAT && hi) return {1'b1, {RW{1'b1}}};
    if (SAT && lo) return {1'b1, {RW{1'b0}}};
    return {hi | lo, full[RW-1:0]};
  endfunction

  // Operand routing for the current chain step.
  always_comb begin
    op_sel = ins.op1;
    x_sel  = RW'(ins.a);
    y_sel  = RW'(ins.d);
    case (state)
      ST_S2: begin
        op_sel = ins.op2;
        x_sel  = w;
        y_sel  = RW'(ins.b);
      end
      ST_S3: begin
        op_sel = ins.op3;
        x_sel  = w;
        y_sel  = RW'(ins.c);
      end
      default: ;
    endcase
    step_res = alu_step(op_sel, x_sel, y_sel);
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ins       <= '0;
      pc        <= '0;
      w         <= '0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc    <= prog_base;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ins     <= instr_t'(rom_data);
          w       <= '0;
          res_ovf <= 1'b0;
          state   <= ST_S1;
        end
        ST_S1: begin
          w       <= step_res[RW-1:0];
          res_ovf <= res_ovf | step_res[RW];
          state   <= ST_S2;
        end
        ST_S2: begin
          w       <= step_res[RW-1:0];
          res_ovf <= res_ovf | step_res[RW];
          state   <= ST_S3;
        end
        ST_S3: begin
          w         <= step_res[RW-1:0];
          res_ovf   <= res_ovf | step_res[RW];
          res_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            // The top address ends the program; pc never wraps.
            if (ins.last || (pc == PC_MAX)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr = pc;
  assign res_data = w;

endmodule

// File: tb/tb_prog_alu_seq.sv
// Bench for prog_alu_seq: wrap (SAT=0) and saturate (SAT=1) instances run in lockstep
// from identical ROM images; expected results are queued at stimulus time.
module tb_prog_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  prog_base;
  logic        res_ready;

  logic [3:0]  rom_addr0, rom_addr1;
  logic [22:0] rom_data0, rom_data1;
  logic        busy0, busy1, res_valid0, res_valid1, res_ovf0, res_ovf1, done0, done1;
  logic [7:0]  res_data0, res_data1;

  logic [22:0] rom [16];
  logic [8:0]  exp0_q [$];
  logic [8:0]  exp1_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data0 = rom[rom_addr0];
  assign rom_data1 = rom[rom_addr1];

  prog_alu_seq #(.DW(4), .RW(8), .ADDR_W(4), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .prog_base(prog_base),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .busy(busy0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_data(res_data0),
    .res_ovf(res_ovf0), .done(done0)
  );

  prog_alu_seq #(.DW(4), .RW(8), .ADDR_W(4), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .prog_base(prog_base),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
    .res_ovf(res_ovf1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [22:0] mkw(input logic last, input logic [1:0] o3, input logic [1:0] o2,
                                      input logic [1:0] o1, input logic [3:0] d, input logic [3:0] c,
                                      input logic [3:0] b, input logic [3:0] a);
    return {last, o3, o2, o1, d, c, b, a};
  endfunction

  // Reference: plain integer arithmetic, clamped or folded back into 8 bits after each step.
  function automatic logic [8:0] model(input logic [22:0] wd, input bit sat);
    int         acc;
    int         y;
    logic [1:0] op;
    logic       ov;
    acc = int'(wd[3:0]);
    ov  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin op = wd[17:16]; y = int'(wd[15:12]); end
      else if (s == 1) begin op = wd[19:18]; y = int'(wd[7:4]); end
      else begin op = wd[21:20]; y = int'(wd[11:8]); end
      case (op)
        2'd0: acc = acc + y;
        2'd1: acc = acc - y;
        2'd2: acc = acc * y;
        default: ;
      endcase
      if (acc > 255) begin ov = 1'b1; acc = sat ? 255 : acc % 256; end
      else if (acc < 0) begin ov = 1'b1; acc = sat ? 0 : acc + 256; end
    end
    return {ov, 8'(acc)};
  endfunction

  task automatic push_model(input logic [22:0] wd);
    exp0_q.push_back(model(wd, 1'b0));
    exp1_q.push_back(model(wd, 1'b1));
  endtask

  task automatic pop_cmp(input string tag);
    logic [8:0] e0, e1;
    chk({tag, "_valid0"}, 32'(res_valid0), 32'd1);
    chk({tag, "_valid1"}, 32'(res_valid1), 32'd1);
    if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
      chk({tag, "_unexpected_result"}, 32'(exp0_q.size()), 32'd1);
    end else begin
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      chk({tag, "_wrap"}, 32'({res_ovf0, res_data0}), 32'(e0));
      chk({tag, "_sat"},  32'({res_ovf1, res_data1}), 32'(e1));
    end
  endtask

  // Start a program and drain results; optional stall on one word and a stray mid-run start.
  task automatic run_prog(input logic [3:0] base, input int stall_idx, input int stall_n,
                          input bit mid_start, input bit no_zero_addr, input int n_exp);
    int idx = 0;
    int stalled = 0;
    int cyc = 0;
    bit fin = 1'b0;
    prog_base = base;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 200) begin
      cyc++;
      if (no_zero_addr) begin
        n_assert++;
        assert (rom_addr0 !== 4'd0) else begin
          n_fail++;
          $error("FAIL addr_zero observed=0x%0h expected=nonzero", rom_addr0);
        end
      end
      if (done0) begin
        chk("done_count", 32'(idx), 32'(n_exp));
        chk("done_busy", 32'(busy0), 32'd0);
        chk("done_sat", 32'(done1), 32'd1);
        fin = 1'b1;
      end else if (res_valid0) begin
        chk("res_addr", 32'(rom_addr0), 32'(4'(base + 4'(idx))));
        if (idx == stall_idx && stalled < stall_n) begin
          if (exp0_q.size() > 0) chk("stall_data", 32'(res_data0), 32'(exp0_q[0][7:0]));
          res_ready = 1'b0;
          stalled++;
        end else begin
          pop_cmp($sformatf("word%0d", idx));
          res_ready = 1'b1;
          idx++;
        end
      end
      start = (mid_start && (cyc == 3 || cyc == 8)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    if (!fin) chk("run_timeout", 32'(fin), 32'd1);
    chk("done_pulse_end", 32'(done0), 32'd0);
    chk("q_empty0", 32'(exp0_q.size()), 32'd0);
    chk("q_empty1", 32'(exp1_q.size()), 32'd0);
    exp0_q.delete();
    exp1_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prog_base = 4'd0;
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0]  = mkw(1'b1, 2'd1, 2'd2, 2'd0, 4'd4,  4'd1,  4'd3,  4'd2);
    rom[1]  = mkw(1'b1, 2'd1, 2'd2, 2'd0, 4'd15, 4'd0,  4'd15, 4'd15);
    rom[2]  = mkw(1'b1, 2'd1, 2'd2, 2'd0, 4'd0,  4'd5,  4'd1,  4'd1);
    rom[3]  = mkw(1'b1, 2'd3, 2'd3, 2'd3, 4'd12, 4'd3,  4'd9,  4'd7);
    rom[4]  = mkw(1'b0, 2'd2, 2'd0, 2'd1, 4'd5,  4'd13, 4'd6,  4'd9);
    rom[5]  = mkw(1'b0, 2'd2, 2'd1, 2'd2, 4'd12, 4'd10, 4'd7,  4'd3);
    rom[6]  = mkw(1'b1, 2'd1, 2'd0, 2'd3, 4'd0,  4'd2,  4'd15, 4'd0);
    rom[14] = mkw(1'b0, 2'd0, 2'd2, 2'd0, 4'd3,  4'd9,  4'd4,  4'd5);
    rom[15] = mkw(1'b0, 2'd1, 2'd1, 2'd2, 4'd8,  4'd1,  4'd2,  4'd6);
    repeat (3) tick();

    chk("rst_rom_addr", 32'(rom_addr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(res_valid0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_data", 32'(res_data0), 32'd0);
    chk("rst_ovf", 32'(res_ovf0), 32'd0);
    rst = 1'b0;
    tick();

    // Basic word with cycle-exact timing
    exp0_q.push_back({1'b0, 8'h11});
    exp1_q.push_back({1'b0, 8'h11});
    prog_base = 4'd0;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("basic_busy_c%0d", c), 32'(busy0), 32'd1);
      chk($sformatf("basic_novalid_c%0d", c), 32'(res_valid0), 32'd0);
      tick();
    end
    chk("basic_busy_c5", 32'(busy0), 32'd1);
    pop_cmp("basic_c5");
    tick();
    chk("basic_done_c6", 32'(done0), 32'd1);
    chk("basic_busy_c6", 32'(busy0), 32'd0);
    chk("basic_valid_c6", 32'(res_valid0), 32'd0);
    tick();
    chk("basic_done_c7", 32'(done0), 32'd0);

    // Overflow, underflow and pass words (values fixed by hand)
    exp0_q.push_back({1'b1, 8'hC2});
    exp1_q.push_back({1'b1, 8'hFF});
    run_prog(4'd1, -1, 0, 1'b0, 1'b0, 1);
    exp0_q.push_back({1'b1, 8'hFC});
    exp1_q.push_back({1'b1, 8'h00});
    run_prog(4'd2, -1, 0, 1'b0, 1'b0, 1);
    exp0_q.push_back({1'b0, 8'h07});
    exp1_q.push_back({1'b0, 8'h07});
    run_prog(4'd3, -1, 0, 1'b0, 1'b0, 1);

    // Three-word program, 3-cycle stall on word 1, stray start pulses mid-run
    push_model(rom[4]);
    push_model(rom[5]);
    push_model(rom[6]);
    run_prog(4'd4, 1, 3, 1'b1, 1'b0, 3);

    // Top-of-ROM termination without last bits
    push_model(rom[14]);
    push_model(rom[15]);
    run_prog(4'd14, -1, 0, 1'b0, 1'b1, 2);

    // Reset during S2 of word 1
    push_model(rom[4]);
    prog_base = 4'd4;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    pop_cmp("rst_run_word0");
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_valid", 32'(res_valid0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr0), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("midrst_quiet_valid%0d", c), 32'(res_valid0), 32'd0);
      chk($sformatf("midrst_quiet_done%0d", c), 32'(done0), 32'd0);
    end
    push_model(rom[4]);
    push_model(rom[5]);
    push_model(rom[6]);
    run_prog(4'd4, -1, 0, 1'b0, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_alu_seq.md
# prog_alu_seq

Parametrised successor to the fixed four-register accumulator datapath. It fetches instruction words from an external combinational program ROM, starting at a programmable base address. Each word is evaluated as a three-step chained ALU expression, `((a op1 d) op2 b) op3 c`, with per-word opcodes and a selectable wrap or saturate mode. Results leave through a valid/ready handshake. The block sits between the program ROM and the result consumer, and replaces the hard-wired `((a+d)*b)-c` sequencer.

## Interface
- DW, 4: operand width (a, b, c, d)
- RW, 8: accumulator/result width, RW >= DW
- ADDR_W, 4: program address width, depth 2^ADDR_W
- SAT, 0: 0 = wrap modulo 2^RW, 1 = unsigned saturate to [0, 2^RW-1]
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request, sampled only in IDLE
- prog_base  in  ADDR_W  first instruction address, captured on accepted start
- rom_addr  out  ADDR_W  program ROM address (= pc)
- rom_data  in  4*DW+7  instruction word {last, op3[1:0], op2[1:0], op1[1:0], d, c, b, a}; a in LSBs; combinational ROM
- busy  out  1  high from the cycle after accepted start until DONE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  RW  result of current word
- res_ovf  out  1  any step of current word wrapped/saturated
- done  out  1  one-cycle pulse, program finished

## Operation
- Opcodes: 0 add, 1 sub, 2 mul, 3 pass (s = x, y ignored).
- Operands zero-extended to RW. Step 1: x = a, y = d. Step 2: x = W, y = b. Step 3: x = W, y = c.
- Arithmetic in RW+RW bits:
  - Add overflow is result >= 2^RW.
  - Mul overflow is product >= 2^RW.
  - Sub underflow is x < y.
- Wrap mode (SAT=0): keep low RW bits.
- Saturate mode (SAT=1): overflow -> 2^RW-1, underflow -> 0.
- Either case sets the sticky res_ovf for the word; res_ovf is cleared in FETCH.
- FSM states: IDLE, FETCH, S1, S2, S3, OUT, DONE.
  - IDLE: start=1 -> pc <= prog_base, go to FETCH.
  - FETCH: latch a/b/c/d/ops/last from rom_data; clear W and ovf; go to S1.
  - S1, S2, S3: W <= step result; advance to the next state.
  - OUT: res_valid=1 with res_data=W. Hold until res_ready=1. On the handshake:
    - last=1, or pc = 2^ADDR_W-1 -> DONE (pc never wraps to 0).
    - otherwise pc <= pc+1, go to FETCH.
  - DONE: done=1, go to IDLE.
- start outside IDLE is ignored. start in DONE is ignored.
- res_data, res_ovf and pc are stable while res_valid=1 and res_ready=0.

## Timing
- Reset values: all outputs 0; rom_addr=0; state IDLE; W, pc, operand registers 0.
- rst in any state, including mid-program or in OUT, returns to IDLE next cycle. No result or done is emitted.
- Accepted start at cycle 0:
  - FETCH at cycle 1.
  - S1/S2/S3 at cycles 2-4.
  - First res_valid at cycle 5.
- With res_ready held high, each subsequent result arrives 5 cycles after the previous one.
- Each cycle res_ready is held low adds one cycle.
- busy is high in FETCH through OUT and low in IDLE and DONE.
- done is high in the cycle after the final handshake.
- rom_addr equals pc combinationally. rom_data is sampled at the end of FETCH only.

## Test plan
- Basic, default parameters: prog_base=0; word0 a=2, b=3, c=1, d=4, op1=add, op2=mul, op3=sub, last=1; start at cycle 0. Required response:
  - res_valid at cycle 5, res_data=0x11, res_ovf=0.
  - done pulse at cycle 6.
  - busy high for cycles 1-5.
- Overflow, SAT=0: a=15, d=15, b=15, c=0, ops add/mul/sub. Required: res_data=0xC2, res_ovf=1. Same word with SAT=1: res_data=0xFF, res_ovf=1.
- Underflow and pass: a=1, d=0, b=1, c=5, ops add/mul/sub. Required: SAT=0 gives 0xFC, SAT=1 gives 0x00, res_ovf=1 in both. Word a=7 with op1=op2=op3=pass gives 0x07, res_ovf=0.
- Backpressure and multi-word program: 3 words, last only on word 2.
  - Hold res_ready low 3 cycles on word 1. res_data and rom_addr must stay constant while stalled.
  - Results arrive in order 0,1,2; done follows the word-2 handshake only.
  - A start pulse mid-run must have no effect.
- Address end: ADDR_W=4, prog_base=14, no last bits set. Required: exactly 2 results (addresses 14 and 15), then done; rom_addr never shows 0 during the run.
- Reset mid-operation: assert rst in S2 of word 1. Required: next cycle IDLE with busy=0, res_valid=0, done=0, rom_addr=0. A subsequent start runs cleanly from prog_base.
